// File: rtl/mem_stage_lsu_pkg.sv
// Shared pipeline definitions for the memory stage: funct3 sizes, result_src
// encodings and the LSU state type.
package pipe_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RS_ALU  = 2'b00;
   localparam logic [1:0] RS_LOAD = 2'b01;
   localparam logic [1:0] RS_PC4  = 2'b10;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2
   } lsu_state_t;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } acc_size_t;

   // Reserved encodings 011/110/111 fall through to word.
   function automatic acc_size_t f3_size(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: return SZ_B;
         F3_H, F3_HU: return SZ_H;
         default:     return SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
import pipe_pkg::*;

interface mem_stage_lsu_if;
   logic            dmem_req_valid;
   logic            dmem_req_ready;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic [3:0]      dmem_wstrb;
   logic            dmem_rsp_valid;
   logic [XLEN-1:0] dmem_rdata;

   modport master (
      output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
   );

   modport slave (
      input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      output dmem_req_ready, dmem_rsp_valid, dmem_rdata
   );
endinterface

// File: rtl/mem_stage_lsu_load_format.sv
// Load data extraction: selects byte/halfword by address offset and extends
// according to funct3.
module load_format
   import pipe_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      off,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (off)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = off[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   data = {24'b0, byte_sel};
         F3_H:    data = {{16{half_sel[15]}}, half_sel};
         F3_HU:   data = {16'b0, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives the data-memory handshake, stalls the
// pipe while an access is outstanding, and registers the MEM/WB outputs.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no access in flight; new access requested combinationally
// REQ      | request presented but not yet accepted; held stable
// WAIT_RSP | load accepted; waiting for dmem_rsp_valid
module mem_stage_lsu
   import pipe_pkg::*;
#(
   parameter logic [1:0] RESULT_SRC_LOAD = RS_LOAD
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            reg_write_m,
   input  logic [1:0]      result_src_m,
   input  logic            mem_write_m,
   input  logic [2:0]      funct3_m,
   input  logic [XLEN-1:0] alu_result_m,
   input  logic [XLEN-1:0] wdata_m,
   input  logic [4:0]      rdm,
   input  logic [XLEN-1:0] pc_plus4_m,
   mem_stage_lsu_if.master dmem,
   output logic            stall_m,
   output logic            reg_write_w,
   output logic [1:0]      result_src_w,
   output logic [XLEN-1:0] alu_result_w,
   output logic [XLEN-1:0] read_data_w,
   output logic [4:0]      rdw,
   output logic [XLEN-1:0] pc_plus4_w
`ifdef MISALIGN_TRAP_EN
   ,
   output logic            misalign_m
`endif
);

   lsu_state_t      state, state_nxt;
   logic [1:0]      off;
   acc_size_t       size;
   logic            is_load;
   logic            is_store;
   logic            access;
   logic            mis;
   logic            req_valid;
   logic            stall;
   logic            load_done;
   logic [3:0]      st_strb;
   logic [XLEN-1:0] st_data;
   logic [XLEN-1:0] ld_data;

   always_comb begin
      off      = alu_result_m[1:0];
      size     = f3_size(funct3_m);
      is_store = mem_write_m;
      is_load  = !mem_write_m && (result_src_m == RESULT_SRC_LOAD);
      access   = mem_write_m || (result_src_m == RESULT_SRC_LOAD);
`ifdef MISALIGN_TRAP_EN
      mis = reset && (state == IDLE) && access &&
            (((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00)));
`else
      mis = 1'b0;
`endif
   end

   always_comb begin
      state_nxt = state;
      req_valid = 1'b0;
      stall     = 1'b0;
      load_done = 1'b0;
      case (state)
         IDLE: begin
            if (access && !mis) begin
               req_valid = 1'b1;
               if (dmem.dmem_req_ready) begin
                  if (is_load) begin
                     stall     = 1'b1;
                     state_nxt = WAIT_RSP;
                  end
               end else begin
                  stall     = 1'b1;
                  state_nxt = REQ;
               end
            end
         end
         REQ: begin
            req_valid = 1'b1;
            if (dmem.dmem_req_ready) begin
               if (is_load) begin
                  stall     = 1'b1;
                  state_nxt = WAIT_RSP;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               stall = 1'b1;
            end
         end
         WAIT_RSP: begin
            if (dmem.dmem_rsp_valid) begin
               load_done = 1'b1;
               state_nxt = IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Reset silences the bus and the stall even if an access was in flight.
      if (!reset) begin
         state_nxt = IDLE;
         req_valid = 1'b0;
         stall     = 1'b0;
         load_done = 1'b0;
      end
   end

   always_comb begin
      st_strb = 4'b0000;
      st_data = '0;
      case (size)
         SZ_B: begin
            st_strb = 4'b0001 << off;
            st_data = {4{wdata_m[7:0]}};
         end
         SZ_H: begin
            st_strb = off[1] ? 4'b1100 : 4'b0011;
            st_data = {2{wdata_m[15:0]}};
         end
         default: begin
            st_strb = 4'b1111;
            st_data = wdata_m;
         end
      endcase
   end

   assign dmem.dmem_req_valid = req_valid;
   assign dmem.dmem_we        = req_valid && is_store;
   assign dmem.dmem_addr      = req_valid ? {alu_result_m[XLEN-1:2], 2'b00} : '0;
   assign dmem.dmem_wdata     = (req_valid && is_store) ? st_data : '0;
   assign dmem.dmem_wstrb     = (req_valid && is_store) ? st_strb : 4'b0000;
   assign stall_m             = stall;
`ifdef MISALIGN_TRAP_EN
   assign misalign_m          = mis;
`endif

   load_format u_load_format (
      .funct3 (funct3_m),
      .off    (off),
      .rdata  (dmem.dmem_rdata),
      .data   (ld_data)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset || stall || mis) begin
         reg_write_w  <= 1'b0;
         result_src_w <= 2'b00;
         alu_result_w <= '0;
         read_data_w  <= '0;
         rdw          <= 5'd0;
         pc_plus4_w   <= '0;
      end else begin
         reg_write_w  <= reg_write_m;
         result_src_w <= result_src_m;
         alu_result_w <= alu_result_m;
         read_data_w  <= load_done ? ld_data : '0;
         rdw          <= rdm;
         pc_plus4_w   <= pc_plus4_m;
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with hand-computed expectations; covers the
// MISALIGN_TRAP_EN path when that macro is defined.
module tb_mem_stage_lsu;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        reg_write_m;
   logic [1:0]  result_src_m;
   logic        mem_write_m;
   logic [2:0]  funct3_m;
   logic [31:0] alu_result_m;
   logic [31:0] wdata_m;
   logic [4:0]  rdm;
   logic [31:0] pc_plus4_m;
   logic        stall_m;
   logic        reg_write_w;
   logic [1:0]  result_src_w;
   logic [31:0] alu_result_w;
   logic [31:0] read_data_w;
   logic [4:0]  rdw;
   logic [31:0] pc_plus4_w;
`ifdef MISALIGN_TRAP_EN
   logic        misalign_m;
`endif

   int checks   = 0;
   int failures = 0;

   mem_stage_lsu_if dmem_if ();

   mem_stage_lsu dut (
      .clk          (clk),
      .reset        (reset),
      .reg_write_m  (reg_write_m),
      .result_src_m (result_src_m),
      .mem_write_m  (mem_write_m),
      .funct3_m     (funct3_m),
      .alu_result_m (alu_result_m),
      .wdata_m      (wdata_m),
      .rdm          (rdm),
      .pc_plus4_m   (pc_plus4_m),
      .dmem         (dmem_if),
      .stall_m      (stall_m),
      .reg_write_w  (reg_write_w),
      .result_src_w (result_src_w),
      .alu_result_w (alu_result_w),
      .read_data_w  (read_data_w),
      .rdw          (rdw),
      .pc_plus4_w   (pc_plus4_w)
`ifdef MISALIGN_TRAP_EN
      ,
      .misalign_m   (misalign_m)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_op(input logic rw, input logic [1:0] rs, input logic mw,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
      reg_write_m  = rw;
      result_src_m = rs;
      mem_write_m  = mw;
      funct3_m     = f3;
      alu_result_m = addr;
      wdata_m      = wd;
      rdm          = rd;
   endtask

   initial begin
      reset = 1'b0;
      set_op(1'b0, RS_ALU, 1'b0, F3_W, 32'h0, 32'h0, 5'd0);
      pc_plus4_m             = 32'h0;
      dmem_if.dmem_req_ready = 1'b0;
      dmem_if.dmem_rsp_valid = 1'b0;
      dmem_if.dmem_rdata     = 32'h0;
      @(negedge clk);
      tick();

      // reset state
      chk("rst_stall", {31'b0, stall_m}, 32'h0);
      chk("rst_req_valid", {31'b0, dmem_if.dmem_req_valid}, 32'h0);
      chk("rst_reg_write_w", {31'b0, reg_write_w}, 32'h0);
      chk("rst_alu_result_w", alu_result_w, 32'h0);
      reset = 1'b1;

      // ALU pass-through
      set_op(1'b1, RS_ALU, 1'b0, F3_W, 32'h1234, 32'h0, 5'd5);
      pc_plus4_m = 32'h44;
      #1;
      chk("alu_stall", {31'b0, stall_m}, 32'h0);
      chk("alu_req_valid", {31'b0, dmem_if.dmem_req_valid}, 32'h0);
      tick();
      chk("alu_reg_write_w", {31'b0, reg_write_w}, 32'h1);
      chk("alu_rdw", {27'b0, rdw}, 32'd5);
      chk("alu_result_w", alu_result_w, 32'h1234);
      chk("alu_pc_plus4_w", pc_plus4_w, 32'h44);

      // sb to 0x103
      set_op(1'b0, RS_ALU, 1'b1, F3_B, 32'h103, 32'hAB, 5'd0);
      dmem_if.dmem_req_ready = 1'b1;
      #1;
      chk("sb_req_valid", {31'b0, dmem_if.dmem_req_valid}, 32'h1);
      chk("sb_we", {31'b0, dmem_if.dmem_we}, 32'h1);
      chk("sb_addr", dmem_if.dmem_addr, 32'h100);
      chk("sb_wstrb", {28'b0, dmem_if.dmem_wstrb}, 32'h8);
      chk("sb_wdata", dmem_if.dmem_wdata, 32'hABABABAB);
      chk("sb_stall", {31'b0, stall_m}, 32'h0);
      tick();

      // sh to 0x106 -> upper half
      set_op(1'b0, RS_ALU, 1'b1, F3_H, 32'h106, 32'h1234CDEF, 5'd0);
      #1;
      chk("sh_wstrb", {28'b0, dmem_if.dmem_wstrb}, 32'hC);
      chk("sh_wdata", dmem_if.dmem_wdata, 32'hCDEFCDEF);
      chk("sh_stall", {31'b0, stall_m}, 32'h0);
      tick();

      // lb at 0x102, one stall cycle then response
      set_op(1'b1, RS_LOAD, 1'b0, F3_B, 32'h102, 32'h0, 5'd7);
      #1;
      chk("lb_req_valid", {31'b0, dmem_if.dmem_req_valid}, 32'h1);
      chk("lb_we", {31'b0, dmem_if.dmem_we}, 32'h0);
      chk("lb_wstrb", {28'b0, dmem_if.dmem_wstrb}, 32'h0);
      chk("lb_addr", dmem_if.dmem_addr, 32'h100);
      chk("lb_stall", {31'b0, stall_m}, 32'h1);
      tick();
      chk("lb_bubble", {31'b0, reg_write_w}, 32'h0);
      dmem_if.dmem_req_ready = 1'b0;
      dmem_if.dmem_rsp_valid = 1'b1;
      dmem_if.dmem_rdata     = 32'h0080FF00;
      #1;
      chk("lb_rsp_stall", {31'b0, stall_m}, 32'h0);
      chk("lb_rsp_req_valid", {31'b0, dmem_if.dmem_req_valid}, 32'h0);
      tick();
      chk("lb_read_data_w", read_data_w, 32'hFFFFFF80);
      chk("lb_reg_write_w", {31'b0, reg_write_w}, 32'h1);
      chk("lb_rdw", {27'b0, rdw}, 32'd7);
      chk("lb_result_src_w", {30'b0, result_src_w}, 32'h1);

      // lbu, lhu, lw against the same word
      dmem_if.dmem_rsp_valid = 1'b0;
      dmem_if.dmem_req_ready = 1'b1;
      funct3_m = F3_BU;
      tick();
      dmem_if.dmem_rsp_valid = 1'b1;
      tick();
      chk("lbu_read_data_w", read_data_w, 32'h00000080);
      dmem_if.dmem_rsp_valid = 1'b0;
      set_op(1'b1, RS_LOAD, 1'b0, F3_HU, 32'h100, 32'h0, 5'd8);
      tick();
      dmem_if.dmem_rsp_valid = 1'b1;
      tick();
      chk("lhu_read_data_w", read_data_w, 32'h0000FF00);
      dmem_if.dmem_rsp_valid = 1'b0;
      set_op(1'b1, RS_LOAD, 1'b0, F3_W, 32'h100, 32'h0, 5'd9);
      tick();
      dmem_if.dmem_rsp_valid = 1'b1;
      tick();
      chk("lw_read_data_w", read_data_w, 32'h0080FF00);
      dmem_if.dmem_rsp_valid = 1'b0;

      // sw with ready low for 3 cycles
      set_op(1'b1, RS_ALU, 1'b1, F3_W, 32'h20C, 32'hDEADBEEF, 5'd3);
      dmem_if.dmem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("sw_hold_req_valid", {31'b0, dmem_if.dmem_req_valid}, 32'h1);
         chk("sw_hold_addr", dmem_if.dmem_addr, 32'h20C);
         chk("sw_hold_wdata", dmem_if.dmem_wdata, 32'hDEADBEEF);
         chk("sw_hold_wstrb", {28'b0, dmem_if.dmem_wstrb}, 32'hF);
         chk("sw_hold_stall", {31'b0, stall_m}, 32'h1);
         tick();
         chk("sw_hold_bubble", {31'b0, reg_write_w}, 32'h0);
         chk("sw_hold_bubble_alu", alu_result_w, 32'h0);
      end
      dmem_if.dmem_req_ready = 1'b1;
      #1;
      chk("sw_ready_stall", {31'b0, stall_m}, 32'h0);
      tick();
      chk("sw_done_reg_write_w", {31'b0, reg_write_w}, 32'h1);
      chk("sw_done_alu_result_w", alu_result_w, 32'h20C);

      // lh abandoned by reset in WAIT_RSP
      set_op(1'b1, RS_LOAD, 1'b0, F3_H, 32'h200, 32'h0, 5'd4);
      tick();
      dmem_if.dmem_req_ready = 1'b0;
      reset = 1'b0;
      #1;
      chk("rstmid_stall", {31'b0, stall_m}, 32'h0);
      chk("rstmid_req_valid", {31'b0, dmem_if.dmem_req_valid}, 32'h0);
      tick();
      chk("rstmid_reg_write_w", {31'b0, reg_write_w}, 32'h0);
      chk("rstmid_rdw", {27'b0, rdw}, 32'h0);
      chk("rstmid_pc_plus4_w", pc_plus4_w, 32'h0);
      chk("rstmid_read_data_w", read_data_w, 32'h0);
      reset = 1'b1;
      dmem_if.dmem_rsp_valid = 1'b1;
      dmem_if.dmem_rdata     = 32'h12345678;
      #1;
      chk("postrst_req_valid", {31'b0, dmem_if.dmem_req_valid}, 32'h1);
      chk("postrst_stall", {31'b0, stall_m}, 32'h1);
      tick();
      chk("postrst_read_data_w", read_data_w, 32'h0);
      chk("postrst_reg_write_w", {31'b0, reg_write_w}, 32'h0);
      dmem_if.dmem_rsp_valid = 1'b0;
      dmem_if.dmem_req_ready = 1'b1;
      tick();
      dmem_if.dmem_req_ready = 1'b0;
      dmem_if.dmem_rsp_valid = 1'b1;
      dmem_if.dmem_rdata     = 32'h00008001;
      tick();
      chk("lh_read_data_w", read_data_w, 32'hFFFF8001);
      chk("lh_rdw", {27'b0, rdw}, 32'd4);
      dmem_if.dmem_rsp_valid = 1'b0;

`ifdef MISALIGN_TRAP_EN
      set_op(1'b1, RS_LOAD, 1'b0, F3_W, 32'h202, 32'h0, 5'd6);
      dmem_if.dmem_req_ready = 1'b1;
      #1;
      chk("mis_req_valid", {31'b0, dmem_if.dmem_req_valid}, 32'h0);
      chk("mis_flag", {31'b0, misalign_m}, 32'h1);
      chk("mis_stall", {31'b0, stall_m}, 32'h0);
      tick();
      chk("mis_bubble", {31'b0, reg_write_w}, 32'h0);
      set_op(1'b0, RS_ALU, 1'b0, F3_W, 32'h0, 32'h0, 5'd0);
      #1;
      chk("mis_flag_clear", {31'b0, misalign_m}, 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
